// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// Latency: none (wires only).
// Backpressure: none; the datapath consumes every control word as presented.
//
// Ports (master = control FSM side, slave = datapath side):
//   opcode, funct       IR fields, driven by the datapath
//   PCWriteCond..RegDst control strobes/selects, driven by the FSM
//   state_out           current FSM state code, for debug/verification
interface multicycle_control_fsm_if #(
    parameter int OP_W    = 6,
    parameter int FN_W    = 6,
    parameter int ALUOP_W = 4
);
    logic [OP_W-1:0]    opcode;
    logic [FN_W-1:0]    funct;
    logic               PCWriteCond;
    logic               PCWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               MemtoReg;
    logic               IRWrite;
    logic [1:0]         PCSource;
    logic [ALUOP_W-1:0] ALUOp;
    logic [1:0]         ALUSrcB;
    logic               ALUSrcA;
    logic               RegWrite;
    logic               RegDst;
    logic [3:0]         state_out;

    modport master (
        input  opcode, funct,
        output PCWriteCond, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, state_out
    );

    modport slave (
        output opcode, funct,
        input  PCWriteCond, PCWrite, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, state_out
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for the multicycle CPU: sequences fetch/decode/execute/mem/writeback.
// Latency: one state per clock; outputs decode combinationally from the state register.
// Backpressure: none; the sequence advances every cycle, reset aborts it at the next edge.
//
// Ports:
//   clk    system clock, all state changes on posedge
//   reset  synchronous active-high; forces FETCH, outputs show FETCH while asserted
//   bus    master modport: opcode/funct in, every datapath control out, state_out
module multicycle_control_fsm (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_fsm_if.master  bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_RWB    = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_IEXEC  = 4'd10;
    localparam logic [3:0] S_IWB    = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [3:0] state;
    logic [3:0] next_state;
    logic [3:0] out_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Codes 12-15 and illegal opcodes fall through to FETCH via the default.
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      next_state = S_EXEC;
                    OP_LW, OP_SW:  next_state = S_MEMADR;
                    OP_BEQ:        next_state = S_BRANCH;
                    OP_J:          next_state = S_JUMP;
                    OP_ADDI:       next_state = S_IEXEC;
                    default:       next_state = S_FETCH;
                endcase
            end
            S_MEMADR: next_state = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_state = S_MEMWB;
            S_EXEC:   next_state = S_RWB;
            S_IEXEC:  next_state = S_IWB;
            default:  next_state = S_FETCH;
        endcase
    end

    // While reset is held the state register may still hold a mid-instruction
    // code for this cycle; decoding FETCH instead keeps write strobes quiet.
    assign out_state     = reset ? S_FETCH : state;
    assign bus.state_out = state;

    always_comb begin
        bus.PCWriteCond = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUOp       = 4'b0000;
        bus.ALUSrcB     = 2'b00;
        bus.ALUSrcA     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        case (out_state)
            S_FETCH: begin
                bus.MemRead  = 1'b1;
                bus.IRWrite  = 1'b1;
                bus.PCWrite  = 1'b1;
                bus.ALUSrcB  = 2'b01;
                bus.ALUOp    = ALU_ADD;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                bus.ALUSrcB  = 2'b11;
                bus.ALUOp    = ALU_ADD;
            end
            S_MEMADR: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = 2'b10;
                bus.ALUOp    = ALU_ADD;
            end
            S_MEMRD: begin
                bus.MemRead  = 1'b1;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
            end
            S_EXEC: begin
                bus.ALUSrcA  = 1'b1;
                case (bus.funct)
                    FN_ADD:  bus.ALUOp = ALU_ADD;
                    FN_SUB:  bus.ALUOp = ALU_SUB;
                    FN_AND:  bus.ALUOp = ALU_AND;
                    FN_OR:   bus.ALUOp = ALU_OR;
                    FN_SLT:  bus.ALUOp = ALU_SLT;
                    default: bus.ALUOp = ALU_ADD;
                endcase
            end
            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end
            S_BRANCH: begin
                bus.PCWriteCond = 1'b1;
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = ALU_SUB;
                bus.PCSource    = 2'b01;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
            S_IEXEC: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = 2'b10;
                bus.ALUOp    = ALU_ADD;
            end
            S_IWB: begin
                bus.RegWrite = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instruction list, then random
// instructions with occasional mid-instruction resets, checked every cycle
// against an instruction-level model (state path per opcode + control table).
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    logic reset;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcwc;
        logic       pcw;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       irw;
        logic [1:0] pcs;
        logic [3:0] aluop;
        logic [1:0] srcb;
        logic       srca;
        logic       rw;
        logic       rd;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        bit         rst3;
    } dir_t;

    int checks = 0;
    int passes = 0;

    int         exp_state;
    int         path[$];
    logic [5:0] cur_fn;
    bit         inject_at3;
    int         trace[$];
    dir_t       dq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (state_out=%0d)", name, act, exp, bus.state_out);
    endtask

    // Expected states after FETCH for one instruction, by opcode.
    function automatic void build_path(input logic [5:0] op);
        case (op)
            6'b000000: path = '{1, 6, 7};
            6'b100011: path = '{1, 2, 3, 4};
            6'b101011: path = '{1, 2, 5};
            6'b000100: path = '{1, 8};
            6'b000010: path = '{1, 9};
            6'b001000: path = '{1, 10, 11};
            default:   path = '{1};
        endcase
    endfunction

    function automatic logic [3:0] alu_for(input logic [5:0] fn);
        case (fn)
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic ctrl_t spec_ctrl(input int s, input logic [5:0] fn);
        ctrl_t c = '0;
        case (s)
            0:  begin c.mr = 1; c.irw = 1; c.pcw = 1; c.srcb = 2'b01; c.aluop = 4'b0010; end
            1:  begin c.srcb = 2'b11; c.aluop = 4'b0010; end
            2:  begin c.srca = 1; c.srcb = 2'b10; c.aluop = 4'b0010; end
            3:  c.mr = 1;
            4:  begin c.rw = 1; c.m2r = 1; end
            5:  c.mw = 1;
            6:  begin c.srca = 1; c.aluop = alu_for(fn); end
            7:  begin c.rw = 1; c.rd = 1; end
            8:  begin c.pcwc = 1; c.srca = 1; c.aluop = 4'b0110; c.pcs = 2'b01; end
            9:  begin c.pcw = 1; c.pcs = 2'b10; end
            10: begin c.srca = 1; c.srcb = 2'b10; c.aluop = 4'b0010; end
            11: c.rw = 1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t dut_ctrl();
        ctrl_t c;
        c.pcwc  = bus.PCWriteCond;
        c.pcw   = bus.PCWrite;
        c.mr    = bus.MemRead;
        c.mw    = bus.MemWrite;
        c.m2r   = bus.MemtoReg;
        c.irw   = bus.IRWrite;
        c.pcs   = bus.PCSource;
        c.aluop = bus.ALUOp;
        c.srcb  = bus.ALUSrcB;
        c.srca  = bus.ALUSrcA;
        c.rw    = bus.RegWrite;
        c.rd    = bus.RegDst;
        return c;
    endfunction

    task automatic check_cycle();
        ctrl_t e;
        e = spec_ctrl(exp_state, cur_fn);
        chk("state", 32'(bus.state_out), 32'(exp_state));
        chk("ctrl", 32'(dut_ctrl()), 32'(e));
        chk("mem_excl", 32'(bus.MemRead & bus.MemWrite), 32'd0);
        chk("pc_excl", 32'(bus.PCWrite & bus.PCWriteCond), 32'd0);
        if (trace.size() < 26) begin
            trace.push_back(int'(bus.state_out));
            // Literal pins on the directed instructions.
            case (bus.state_out)
                4'd6: chk("lit_exec_aluop", 32'(bus.ALUOp), 32'h6);
                4'd4: chk("lit_memwb", 32'({bus.MemtoReg, bus.RegWrite}), 32'h3);
                4'd5: chk("lit_memwr", 32'({bus.MemWrite, bus.RegWrite}), 32'h2);
                4'd8: chk("lit_branch", 32'({bus.PCWriteCond, bus.PCSource}), 32'h5);
                4'd9: chk("lit_jump_pcs", 32'(bus.PCSource), 32'h2);
                4'd7: chk("lit_rwb", 32'({bus.RegWrite, bus.RegDst}), 32'h3);
                default: ;
            endcase
        end
    endtask

    initial begin
        int lit_trace[26] = '{0, 1, 6, 7,  0, 1, 2, 3, 4,  0, 1, 2, 5,
                              0, 1, 8,  0, 1, 9,  0, 1,  0, 1, 2, 3, 0};
        logic [5:0] ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        dq.push_back('{6'b000000, 6'b100010, 1'b0});
        dq.push_back('{6'b100011, 6'b000000, 1'b0});
        dq.push_back('{6'b101011, 6'b000000, 1'b0});
        dq.push_back('{6'b000100, 6'b000000, 1'b0});
        dq.push_back('{6'b000010, 6'b000000, 1'b0});
        dq.push_back('{6'b111111, 6'b000000, 1'b0});
        dq.push_back('{6'b100011, 6'b000000, 1'b1});

        bus.opcode = '0;
        bus.funct  = '0;
        cur_fn     = '0;
        inject_at3 = 1'b0;
        reset      = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);

        chk("reset_state", 32'(bus.state_out), 32'd0);
        chk("reset_strobes", 32'({bus.PCWrite, bus.IRWrite, bus.MemRead}), 32'h7);
        chk("reset_aluop", 32'(bus.ALUOp), 32'h2);
        exp_state = 0;
        path.delete();
        check_cycle();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit do_rst;
            do_rst = 1'b0;
            if (inject_at3 && exp_state == 3) begin
                do_rst     = 1'b1;
                inject_at3 = 1'b0;
            end else if (trace.size() >= 26) begin
                do_rst = ($urandom_range(0, 39) == 0);
            end

            if (do_rst) begin
                path.delete();
                exp_state = 0;
            end else begin
                if (exp_state == 0) begin
                    logic [5:0] op;
                    logic [5:0] fn;
                    if (dq.size() > 0) begin
                        dir_t d;
                        d = dq.pop_front();
                        op = d.op;
                        fn = d.fn;
                        inject_at3 = d.rst3;
                    end else begin
                        int r;
                        r  = $urandom_range(0, 6);
                        op = (r < 6) ? ops[r] : 6'($urandom);
                        r  = $urandom_range(0, 5);
                        fn = (r < 5) ? fns[r] : 6'($urandom);
                    end
                    bus.opcode = op;
                    bus.funct  = fn;
                    cur_fn     = fn;
                    build_path(op);
                end
                exp_state = (path.size() > 0) ? path.pop_front() : 0;
            end
            reset = do_rst;
            @(negedge clk);
            check_cycle();
        end

        for (int i = 0; i < 26; i++) begin
            chk($sformatf("trace[%0d]", i), 32'(trace[i]), 32'(lit_trace[i]));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
